// File: rtl/pcler_pkg.sv
// pcler_pkg: shared types and the next-state rule for the pcler counter family.
//   mode_e      : wrap or saturate behaviour at the terminal value
//   word_t      : widest counter word the helper function handles
//   next_count  : next counter value given state, direction, limit and mode,
//                 assuming a count is actually taking place this cycle
package pcler_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } mode_e;

    // Counters up to this width can share the helper function below.
    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // Callers zero-extend q and limit into word_t and truncate the result
    // back to their own width. Truncation makes q + 1 from all-ones roll
    // over to zero, which gives the natural wrap when q sits above limit
    // after a load.
    function automatic word_t next_count(
        input word_t q,
        input logic  dn,
        input word_t limit,
        input mode_e sat
    );
        word_t nxt;
        if (dn) begin
            if (q == '0) begin
                nxt = (sat == SAT) ? q : limit;
            end else begin
                nxt = q - word_t'(1);
            end
        end else begin
            if (q == limit) begin
                nxt = (sat == SAT) ? q : '0;
            end else begin
                nxt = q + word_t'(1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pcler_term_det.sv
// pcler_term_det: combinational terminal-count and carry-out detection.
//   q, limit   : counter state and up-count terminal value
//   dn         : direction (1 = down, terminal is zero)
//   en, ci     : count enable and carry-in
//   clr, ld    : synchronous clear / load requests, which suppress carry-out
//   tc         : terminal-count flag
//   co         : carry-out for ripple cascading (zero-cycle path from ci)
module pcler_term_det
    import pcler_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] limit,
    input  logic             dn,
    input  logic             en,
    input  logic             ci,
    input  logic             clr,
    input  logic             ld,
    output logic             tc,
    output logic             co
);

    // The terminal depends on direction: zero going down, limit going up.
    // Carry-out only fires when a real count happens, so clear or load
    // in the same cycle masks it.
    always_comb begin
        tc = dn ? (q == '0) : (q == limit);
        co = tc & en & ci & ~clr & ~ld;
    end

endmodule

// File: rtl/pcler_counter.sv
// pcler_counter: parametrised loadable up/down counter with carry chaining.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (highest priority)
//   ld, d      : synchronous parallel load (d is not checked against limit)
//   en, ci     : count enable and carry-in, counting needs both
//   dn         : direction, 0 = up, 1 = down
//   limit      : up-count terminal value (down-count terminal is zero)
//   q          : counter state
//   co, tc     : combinational carry-out and terminal-count flag
//   wrap       : one-cycle registered pulse following a terminal event
module pcler_counter
    import pcler_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               SATURATE = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             ci,
    input  logic             dn,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             tc,
    output logic             wrap
);

    localparam mode_e MODE = (SATURATE != 0) ? SAT : WRAP;

    logic             cnt;
    logic [WIDTH-1:0] q_cnt;

    pcler_term_det #(
        .WIDTH (WIDTH)
    ) u_term (
        .q     (q),
        .limit (limit),
        .dn    (dn),
        .en    (en),
        .ci    (ci),
        .clr   (clr),
        .ld    (ld),
        .tc    (tc),
        .co    (co)
    );

    // Value q would take if a count happens this cycle; the shared rule
    // works on a wide word, so extend in and truncate back out.
    always_comb begin
        cnt   = en & ci;
        q_cnt = WIDTH'(next_count(word_t'(q), dn, word_t'(limit), MODE));
    end

    // State register: clear beats load beats count beats hold. The wrap
    // pulse is simply carry-out delayed by one cycle, so it also fires on
    // every counting cycle spent at the terminal in saturate mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_VAL;
            wrap <= 1'b0;
        end else begin
            if (clr) begin
                q <= '0;
            end else if (ld) begin
                q <= d;
            end else if (cnt) begin
                q <= q_cnt;
            end
            wrap <= co;
        end
    end

endmodule

// File: tb/tb_pcler_counter.sv
// tb_pcler_counter: self-checking bench for pcler_counter.
//   Two 8-bit instances (wrap and saturate) share one set of inputs and are
//   compared each cycle with an arithmetic reference model; a pair of 4-bit
//   instances forms a cascade checked as a single 8-bit counter.
`timescale 1ns/1ps
module tb_pcler_counter;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       ld;
    logic [7:0] d;
    logic       en;
    logic       ci;
    logic       dn;
    logic [7:0] limit;

    logic [7:0] q;
    logic       co;
    logic       tc;
    logic       wrap;
    logic [7:0] q_s;
    logic       co_s;
    logic       tc_s;
    logic       wrap_s;

    logic       c_en;
    logic [3:0] lo_q;
    logic       lo_co;
    logic       lo_tc;
    logic       lo_wrap;
    logic [3:0] hi_q;
    logic       hi_co;
    logic       hi_tc;
    logic       hi_wrap;

    int checks;
    int errors;

    int   m_q;
    int   m_qs;
    logic m_wrap;
    logic m_wraps;

    pcler_counter #(.WIDTH(8), .SATURATE(0), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d), .en(en),
        .ci(ci), .dn(dn), .limit(limit), .q(q), .co(co), .tc(tc), .wrap(wrap)
    );

    pcler_counter #(.WIDTH(8), .SATURATE(1), .RST_VAL(8'h00)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d), .en(en),
        .ci(ci), .dn(dn), .limit(limit), .q(q_s), .co(co_s), .tc(tc_s),
        .wrap(wrap_s)
    );

    pcler_counter #(.WIDTH(4), .SATURATE(0), .RST_VAL(4'h0)) casc_lo (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .ld(1'b0), .d(4'h0), .en(c_en),
        .ci(1'b1), .dn(1'b0), .limit(4'hF), .q(lo_q), .co(lo_co), .tc(lo_tc),
        .wrap(lo_wrap)
    );

    pcler_counter #(.WIDTH(4), .SATURATE(0), .RST_VAL(4'h0)) casc_hi (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .ld(1'b0), .d(4'h0), .en(c_en),
        .ci(lo_co), .dn(1'b0), .limit(4'hF), .q(hi_q), .co(hi_co), .tc(hi_tc),
        .wrap(hi_wrap)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s_clr, input logic s_ld,
                                  input logic [7:0] s_d, input logic s_en,
                                  input logic s_ci, input logic s_dn,
                                  input logic [7:0] s_limit);
        clr   = s_clr;
        ld    = s_ld;
        d     = s_d;
        en    = s_en;
        ci    = s_ci;
        dn    = s_dn;
        limit = s_limit;
    endtask

    // Reference rule, straight from the counting behaviour: clear, then
    // load, then a count that rolls over modulo 256 or stops at the
    // terminal, else hold.
    function automatic int model_next(input int cur, input bit sat);
        int lim;
        lim = int'(limit);
        if (clr) return 0;
        if (ld) return int'(d);
        if (!(en && ci)) return cur;
        if (!dn) begin
            if (cur == lim) return sat ? cur : 0;
            return (cur + 1) % 256;
        end
        if (cur == 0) return sat ? 0 : lim;
        return cur - 1;
    endfunction

    function automatic logic model_tc(input int cur);
        return dn ? (cur == 0) : (cur == int'(limit));
    endfunction

    // One clock cycle: check combinational flags against the current
    // inputs, clock, then check registered state against the model.
    task automatic step();
        logic e_co;
        logic e_cos;
        #1;
        e_co  = model_tc(m_q)  & en & ci & ~clr & ~ld;
        e_cos = model_tc(m_qs) & en & ci & ~clr & ~ld;
        check_output("tc",     32'(tc),   32'(model_tc(m_q)));
        check_output("co",     32'(co),   32'(e_co));
        check_output("tc_sat", 32'(tc_s), 32'(model_tc(m_qs)));
        check_output("co_sat", 32'(co_s), 32'(e_cos));
        @(posedge clk);
        #1;
        m_q     = model_next(m_q, 1'b0);
        m_qs    = model_next(m_qs, 1'b1);
        m_wrap  = e_co;
        m_wraps = e_cos;
        check_output("q",        32'(q),      32'(m_q));
        check_output("wrap",     32'(wrap),   32'(m_wrap));
        check_output("q_sat",    32'(q_s),    32'(m_qs));
        check_output("wrap_sat", 32'(wrap_s), 32'(m_wraps));
    endtask

    initial begin
        int c_val;
        int c_prev;
        int pulses;

        checks  = 0;
        errors  = 0;
        m_q     = 0;
        m_qs    = 0;
        m_wrap  = 1'b0;
        m_wraps = 1'b0;
        c_en    = 1'b0;
        rst_n   = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF);

        // Reset state, then release away from a clock edge.
        #12;
        check_output("rst_q",    32'(q),    32'h0);
        check_output("rst_wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load 5A, start counting, then reset asynchronously mid-cycle
        // with a load pending.
        apply_stimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'hFF);
        step();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF);
        step();
        apply_stimulus(1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        m_q = 0; m_qs = 0; m_wrap = 1'b0; m_wraps = 1'b0;
        check_output("async_rst_q",    32'(q),    32'h0);
        check_output("async_rst_wrap", 32'(wrap), 32'h0);
        @(posedge clk);
        #1;
        check_output("rst_hold_q", 32'(q), 32'h0);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF);
        #2;
        rst_n = 1'b1;
        step();
        step();

        // Up wrap at limit FF from FE.
        apply_stimulus(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFF);
        step();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF);
        step();
        step();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF);
        step();
        check_output("upwrap_q", 32'(q), 32'h0);

        // Down count to zero with limit 9.
        apply_stimulus(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 8'd9);
        step();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd9);
        step();
        step();
        step();
        check_output("down_reload_q", 32'(q), 32'd8);
        check_output("down_sat_q",    32'(q_s), 32'd0);

        // Priority: clear over load over count.
        apply_stimulus(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'hFF);
        step();
        apply_stimulus(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'hFF);
        step();
        apply_stimulus(1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'hFF);
        step();
        check_output("prio_q", 32'(q), 32'h44);

        // Load above limit, then count up through all-ones back to limit.
        apply_stimulus(1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0, 8'd10);
        step();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd10);
        for (int i = 0; i < 70; i++) step();
        apply_stimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd10);
        step();

        // Cascade of two 4-bit stages behaves as one 8-bit counter.
        c_val  = 0;
        pulses = 0;
        c_en   = 1'b1;
        for (int i = 0; i < 257; i++) begin
            c_prev = c_val;
            @(posedge clk);
            #1;
            c_val = (c_val + 1) % 256;
            check_output("casc_q", 32'({hi_q, lo_q}), 32'(c_val));
            check_output("casc_wrap", 32'(hi_wrap), 32'(c_prev == 255));
            if (hi_wrap === 1'b1) pulses++;
        end
        c_en = 1'b0;
        check_output("casc_pulses", 32'(pulses), 32'd1);

        // Randomized traffic, including limit moves below q.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom % 25) == 0, ($urandom % 12) == 0,
                           8'($urandom), ($urandom % 5) != 0,
                           ($urandom % 6) != 0,
                           (i % 40) < 12 ? 1'($urandom) : 1'b0,
                           (($urandom % 16) == 0) ? 8'($urandom_range(0, 255))
                                                  : limit);
            if (i < 3) limit = 8'($urandom_range(5, 30));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
